// File: rtl/sgx_reset_pkg.sv
// Shared state encoding for the SGX shell reset sequencer.
package sgx_reset_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_HOLD   = 3'd4,
        ST_SW_ACK    = 3'd5
    } state_e;

endpackage

// File: rtl/sgx_sync2.sv
// Two-flop synchronizer with asynchronous clear for a single level signal.
module sgx_sync2 (
    input  logic clock,
    input  logic areset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sgx_reset_ctrl.sv
// Sequences per-domain reset release after qualified PLL lock, and services
// a level software reset request/acknowledge handshake.
module sgx_reset_ctrl
    import sgx_reset_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned LOCK_CYCLES    = 1024,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned SW_HOLD_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   clock,
    input  logic                   areset,
    input  logic                   pll_locked,
    input  logic                   sw_req,
    output logic                   sw_ack,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   all_released,
    output logic [STATE_W-1:0]     state_o
);

    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(SW_HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_ONES  = '1;
    // Releasing domain 0 from a fully held vector.
    localparam logic [NUM_DOMAINS-1:0] FIRST_REL = ALL_ONES << 1;

    logic lk;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   ack_q, ack_d;
    logic                   rel_q, rel_d;

    sgx_sync2 u_lock_sync (
        .clock  (clock),
        .areset (areset),
        .d      (pll_locked),
        .q      (lk)
    );

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= ALL_ONES;
            ack_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ack_q   <= ack_d;
            rel_q   <= rel_d;
        end
    end

    // Next-state logic; lock loss overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ack_d   = ack_q;
        rel_d   = rel_q;

        if (state_q != ST_WAIT_LOCK && !lk) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = ALL_ONES;
            ack_d   = 1'b0;
            rel_d   = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    rst_d = ALL_ONES;
                    if (lk) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
                end
                ST_STABLE: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = FIRST_REL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            rel_d   = 1'b1;
                        end else begin
                            // Bits release strictly in order, so a left shift clears bit idx+1.
                            idx_d = idx_q + IDX_W'(1);
                            rst_d = rst_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    rst_d = '0;
                    if (sw_req) begin
                        state_d = ST_SW_HOLD;
                        cnt_d   = '0;
                        rst_d   = ALL_ONES;
                        rel_d   = 1'b0;
                    end
                end
                ST_SW_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_SW_ACK;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SW_ACK: begin
                    if (!sw_req) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        ack_d   = 1'b0;
                        rst_d   = FIRST_REL;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = ALL_ONES;
                    ack_d   = 1'b0;
                    rel_d   = 1'b0;
                end
            endcase
        end
    end

    assign state_o      = state_q;
    assign rst_out      = rst_q;
    assign sw_ack       = ack_q;
    assign all_released = rel_q;

endmodule

// File: tb/tb_sgx_reset_ctrl.sv
// Self-checking bench for sgx_reset_ctrl with a timeline-based reference model.
module tb_sgx_reset_ctrl;

    localparam int N     = 4;
    localparam int LOCK  = 8;
    localparam int GAP   = 4;
    localparam int HOLD  = 6;
    localparam int SYNC  = 2;
    localparam int EXP_W = 3 + N + 2;

    // Edge numbers, counted from the cycle pll_locked first goes high.
    localparam int T_STABLE = SYNC + 1;
    localparam int T_E0     = T_STABLE + LOCK;
    localparam int T_RUN    = T_E0 + N * GAP;

    localparam logic [N-1:0] ONES = '1;

    logic         clock = 1'b0;
    logic         areset;
    logic         pll_locked;
    logic         sw_req;
    logic         sw_ack;
    logic [N-1:0] rst_out;
    logic         all_released;
    logic [2:0]   state_o;

    logic [EXP_W-1:0] got;
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    assign got = {state_o, rst_out, sw_ack, all_released};

    sgx_reset_ctrl #(
        .NUM_DOMAINS    (N),
        .LOCK_CYCLES    (LOCK),
        .GAP_CYCLES     (GAP),
        .SW_HOLD_CYCLES (HOLD),
        .CNT_W          (16)
    ) dut (
        .clock        (clock),
        .areset       (areset),
        .pll_locked   (pll_locked),
        .sw_req       (sw_req),
        .sw_ack       (sw_ack),
        .rst_out      (rst_out),
        .all_released (all_released),
        .state_o      (state_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=%b required=finish", cyc, got);
        $fatal(1, "watchdog");
    end

    // Held mask t cycles after the first release edge.
    function automatic logic [N-1:0] rel_mask(int t);
        logic [N-1:0] ones;
        int released;
        ones     = '1;
        released = (t >= N * GAP) ? N : (t / GAP + 1);
        return ones << released;
    endfunction

    // Expected {state, rst_out, sw_ack, all_released} at edge t of a lock-up.
    function automatic logic [EXP_W-1:0] pu_exp(int t);
        if (t < T_STABLE) return {3'd0, ONES, 1'b0, 1'b0};
        if (t < T_E0)     return {3'd1, ONES, 1'b0, 1'b0};
        if (t < T_RUN)    return {3'd2, rel_mask(t - T_E0), 1'b0, 1'b0};
        return {3'd3, rel_mask(t - T_E0), 1'b0, 1'b1};
    endfunction

    // Lock-up, sw_req first seen at edge r+1, dropped after edge d.
    function automatic logic [EXP_W-1:0] sw_exp(int t, int r, int d);
        int tr;
        if (t <= r)            return pu_exp(t);
        if (t < r + 1 + HOLD)  return {3'd4, ONES, 1'b0, 1'b0};
        if (t <= d)            return {3'd5, ONES, 1'b1, 1'b0};
        tr = t - (d + 1);
        return {(tr >= N * GAP) ? 3'd3 : 3'd2, rel_mask(tr), 1'b0, (tr >= N * GAP)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        areset     = 1'b1;
        pll_locked = 1'b0;
        sw_req     = 1'b0;
        @(posedge clock);
        #1;
        areset = 1'b0;
        cyc    = 0;
    endtask

    task automatic test_reset();
        int n;
        logic [EXP_W-1:0] exp_v;
        do_reset();
        pll_locked = 1'b1;
        n = $urandom_range(20, 12);
        for (int i = 0; i < n; i++) tick();
        #3;
        areset = 1'b1;
        #1;
        exp_v = {3'd0, ONES, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_async got=%b required=%b", got, exp_v);
        end
        @(posedge clock);
        #1;
        areset = 1'b0;
        cyc    = 0;
        for (int t = 1; t <= T_STABLE + 1; t++) begin
            tick();
            exp_v = pu_exp(t);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_sync_clear cyc=%0d got=%b required=%b", t, got, exp_v);
            end
        end
    endtask

    task automatic test_powerup();
        logic [EXP_W-1:0] exp_v;
        do_reset();
        pll_locked = 1'b1;
        for (int t = 1; t <= T_RUN + 3; t++) begin
            tick();
            exp_v = pu_exp(t);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL powerup cyc=%0d got=%b required=%b", t, got, exp_v);
            end
        end
    endtask

    task automatic test_lock_glitch();
        int p, l, s;
        logic [EXP_W-1:0] exp_v;
        do_reset();
        pll_locked = 1'b1;
        p = $urandom_range(8, 3);
        l = $urandom_range(4, 1);
        s = p + l + SYNC + 1;
        for (int t = 1; t <= s + LOCK + 3; t++) begin
            tick();
            if (t < T_STABLE)      exp_v = {3'd0, ONES, 1'b0, 1'b0};
            else if (t < p + 3)    exp_v = {3'd1, ONES, 1'b0, 1'b0};
            else if (t < s)        exp_v = {3'd0, ONES, 1'b0, 1'b0};
            else if (t < s + LOCK) exp_v = {3'd1, ONES, 1'b0, 1'b0};
            else                   exp_v = {3'd2, rel_mask(t - s - LOCK), 1'b0, 1'b0};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL lock_glitch p=%0d l=%0d cyc=%0d got=%b required=%b", p, l, t, got, exp_v);
            end
            if (t == p)     pll_locked = 1'b0;
            if (t == p + l) pll_locked = 1'b1;
        end
    endtask

    task automatic test_lock_loss_release();
        int p;
        logic [EXP_W-1:0] exp_v;
        do_reset();
        pll_locked = 1'b1;
        p = $urandom_range(23, 12);
        for (int t = 1; t <= p + 6; t++) begin
            tick();
            exp_v = (t < p + SYNC + 1) ? pu_exp(t) : {3'd0, ONES, 1'b0, 1'b0};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL lock_loss_release p=%0d cyc=%0d got=%b required=%b", p, t, got, exp_v);
            end
            if (t == p) pll_locked = 1'b0;
        end
    endtask

    task automatic test_sw_reset();
        int r, d;
        logic [EXP_W-1:0] exp_v;
        do_reset();
        pll_locked = 1'b1;
        r = T_RUN + $urandom_range(5, 0);
        d = r + 1 + HOLD + $urandom_range(10, 0);
        for (int t = 1; t <= d + 1 + N * GAP + 3; t++) begin
            tick();
            exp_v = sw_exp(t, r, d);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL sw_reset r=%0d d=%0d cyc=%0d got=%b required=%b", r, d, t, got, exp_v);
            end
            if (t == r) sw_req = 1'b1;
            if (t == d) sw_req = 1'b0;
        end
    endtask

    task automatic test_sw_pending();
        int a, d;
        logic [EXP_W-1:0] exp_v;
        do_reset();
        pll_locked = 1'b1;
        a = $urandom_range(10, T_STABLE);
        d = T_RUN + 1 + HOLD + $urandom_range(4, 0);
        for (int t = 1; t <= d + 1 + N * GAP + 3; t++) begin
            tick();
            exp_v = sw_exp(t, T_RUN, d);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL sw_pending a=%0d cyc=%0d got=%b required=%b", a, t, got, exp_v);
            end
            if (t == a) sw_req = 1'b1;
            if (t == d) sw_req = 1'b0;
        end
    endtask

    task automatic test_lock_loss_sw_ack();
        int p, q, d2, holds;
        logic [2:0] prev_st;
        logic [EXP_W-1:0] exp_v;
        do_reset();
        pll_locked = 1'b1;
        p  = T_RUN + 1 + HOLD + $urandom_range(4, 0);
        q  = p + SYNC + 1 + $urandom_range(3, 0);
        d2 = T_RUN + 1 + HOLD + $urandom_range(5, 0);
        holds   = 0;
        prev_st = 3'd0;
        for (int t = 1; t <= q + d2 + 1 + N * GAP + 10; t++) begin
            tick();
            if (t < p + SYNC + 1) exp_v = sw_exp(t, T_RUN, 1 << 30);
            else if (t <= q)      exp_v = {3'd0, ONES, 1'b0, 1'b0};
            else                  exp_v = sw_exp(t - q, T_RUN, d2);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL lock_loss_sw_ack p=%0d q=%0d cyc=%0d got=%b required=%b", p, q, t, got, exp_v);
            end
            if (t > q && state_o == 3'd4 && prev_st != 3'd4) holds++;
            prev_st = state_o;
            if (t == T_RUN)  sw_req     = 1'b1;
            if (t == p)      pll_locked = 1'b0;
            if (t == q)      pll_locked = 1'b1;
            if (t == q + d2) sw_req     = 1'b0;
        end
        checks++;
        if (holds !== 1) begin
            errors++;
            $display("FAIL relock_sw_hold_count got=%0d required=1", holds);
        end
    endtask

    initial begin
        areset     = 1'b1;
        pll_locked = 1'b0;
        sw_req     = 1'b0;
        test_reset();
        test_powerup();
        test_lock_glitch();
        test_lock_glitch();
        test_lock_loss_release();
        test_lock_loss_release();
        test_sw_reset();
        test_sw_reset();
        test_sw_pending();
        test_lock_loss_sw_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgx_reset_ctrl.md
Name: sgx_reset_ctrl

Overview:
Reset sequencing controller for the SGX shell. It waits for PLL lock, qualifies that lock as stable, then releases N domain reset requests in a fixed order with a programmable gap between each. Each request drives one per-domain reset synchronizer. It also services a level-based software reset request/acknowledge handshake and re-asserts every domain when lock is lost.

Parameters:
NUM_DOMAINS, 4, number of reset domains sequenced; legal range 1..16
LOCK_CYCLES, 1024, consecutive synchronized-locked cycles required before the first release; must be >= 1
GAP_CYCLES, 16, cycles between successive domain releases, and after the last release before RUN; must be >= 1
SW_HOLD_CYCLES, 64, minimum cycles all domains are held in reset on a software request; must be >= 1
CNT_W, 16, counter width; must hold max(LOCK_CYCLES, GAP_CYCLES, SW_HOLD_CYCLES)

Ports:
clock  input  1  controller clock; free-running once areset is released
areset  input  1  asynchronous, active-high reset; clock is clock
pll_locked  input  1  PLL lock indication, asynchronous to clock
sw_req  input  1  software reset request, level; synchronous to clock
sw_ack  output  1  high once the software-requested hold has completed
rst_out  output  NUM_DOMAINS  per-domain reset request, 1 = held in reset; bit 0 is released first
all_released  output  1  high only in RUN
state_o  output  3  current FSM state encoding, for debug

Behaviour:
- areset asserted (async) sets the following:
  - state = WAIT_LOCK
  - rst_out = all ones, sw_ack = 0, all_released = 0
  - counter = 0, domain index = 0
  - lock synchronizer flops = 0
- pll_locked passes through a 2-flop synchronizer; lk is the synchronized value and adds 2 cycles of latency. All lock decisions use lk only.
- All outputs are registered. No combinational path exists from any input to any output.
- State encodings: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3, SW_HOLD=4, SW_ACK=5.
- WAIT_LOCK: rst_out all ones. When lk=1, go to STABLE with cnt=0.
- STABLE: cnt increments each cycle while lk=1.
  - lk=0: go to WAIT_LOCK.
  - cnt==LOCK_CYCLES-1: go to RELEASE, idx=0, cnt=0, and clear rst_out[0] on the same edge.
- RELEASE: cnt counts 0..GAP_CYCLES-1.
  - At cnt==GAP_CYCLES-1 with idx<NUM_DOMAINS-1: idx++, clear rst_out[idx+1], cnt=0.
  - At cnt==GAP_CYCLES-1 with idx==NUM_DOMAINS-1: go to RUN and set all_released=1.
  - Resulting timing, with E0 the edge entering RELEASE: rst_out[k] falls at E0 + k*GAP_CYCLES; all_released rises at E0 + NUM_DOMAINS*GAP_CYCLES.
- Released bits stay 0 until a global re-assert. Bits are never released out of order.
- RUN: rst_out all zeros. When sw_req=1: go to SW_HOLD, set rst_out all ones and all_released=0 on the same edge, cnt=0.
- SW_HOLD: count to SW_HOLD_CYCLES-1, then set sw_ack=1 and go to SW_ACK.
- SW_ACK: rst_out stays all ones. When sw_req=0: clear sw_ack, go to RELEASE with idx=0, cnt=0, and clear rst_out[0]. PLL lock qualification is not repeated.
- sw_req is only sampled in RUN and SW_ACK. A request raised in any other state stays pending as a level and is serviced on reaching RUN.
- Lock loss (lk=0) in STABLE, RELEASE, RUN, SW_HOLD or SW_ACK takes priority over every other transition. On the next edge:
  - rst_out = all ones, sw_ack = 0, all_released = 0
  - state = WAIT_LOCK, cnt = 0, idx = 0
- After relock, a still-high sw_req produces one further software reset once RUN is reached.
- sw_req and lock loss on the same cycle: lock loss wins.
- Counters never wrap. They are cleared on every state transition.
- An areset mid-sequence restarts from WAIT_LOCK regardless of the current state.

Decomposition:
- Package sgx_reset_pkg holds the state encoding constants and the STATE_W=3 width constant.
- One sub-module, sgx_sync2: 2-flop synchronizer with async clear, used for pll_locked.
- Counter, index and FSM stay in sgx_reset_ctrl.

Test Plan:
Bench parameters throughout: NUM_DOMAINS=4, LOCK_CYCLES=8, GAP_CYCLES=4, SW_HOLD_CYCLES=6.
- Power-up: areset pulse, then pll_locked=1 at cycle 0 -> STABLE at cycle 3 (2-cycle sync latency); rst_out 1111->1110 at cycle 11, 1100 at 15, 1000 at 19, 0000 at 23; all_released=1 at 27.
- Lock glitch during STABLE: pll_locked low for 3 cycles after 5 qualifying cycles -> back to WAIT_LOCK; rst_out stays 1111; full 8-cycle qualification restarts after relock.
- Lock loss in RELEASE with rst_out=1100 -> rst_out=1111 and state_o=0 two to three cycles after the pll_locked fall; all_released stays 0.
- Software reset in RUN:
  - sw_req=1 -> rst_out=1111 on the next edge; sw_ack=1 six cycles later.
  - sw_req held 10 more cycles -> no release while sw_req is high.
  - sw_req=0 -> sw_ack=0 and rst_out=1110 on the same edge; all_released=1 sixteen cycles after that.
- sw_req asserted during STABLE -> ignored until RUN, then SW_HOLD entered one cycle after all_released rises.
- Lock loss during SW_ACK with sw_req still high -> sw_ack=0, WAIT_LOCK; after relock exactly one additional SW_HOLD occurs.
